// File: rtl/tournament_choice_trainer.sv
// tournament_choice_trainer: 2-bit choice counter table with a registered lookup, two-stage training and a post-reset init sweep
module tournament_choice_trainer #(
    parameter int         IDX_W    = 8,
    parameter logic [1:0] INIT_CTR = 2'b01
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             lookup_v_i,
    input  logic [IDX_W-1:0] lookup_idx_i,
    output logic [1:0]       choice_o,
    output logic             choice_v_o,
    input  logic             update_v_i,
    output logic             update_ready_o,
    input  logic [IDX_W-1:0] update_idx_i,
    input  logic             global_pred_i,
    input  logic             local_pred_i,
    input  logic             taken_i,
    output logic             init_done_o
);
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic {INIT, READY} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [1:0]       mem [DEPTH];
    logic             pend_v, pend_inc;
    logic [IDX_W-1:0] pend_idx;
    logic             accept, train, we;
    logic [1:0]       cur, upd_val, look_val, wdata;
    logic [IDX_W-1:0] waddr;

    // next state: leave INIT once the sweep has reached the last entry
    always_comb begin
        state_nxt      = (state == INIT && &ptr) ? READY : state;
        update_ready_o = state == READY;
        init_done_o    = state == READY;
    end

    // training datapath, lookup bypass of the in-flight write, and the shared write port
    always_comb begin
        accept   = update_v_i && update_ready_o;
        train    = accept && (global_pred_i != local_pred_i);
        cur      = mem[pend_idx];
        upd_val  = pend_inc ? ((cur == 2'b11) ? cur : cur + 2'd1)
                            : ((cur == 2'b00) ? cur : cur - 2'd1);
        look_val = (pend_v && pend_idx == lookup_idx_i) ? upd_val : mem[lookup_idx_i];
        we       = !reset_i && (state == INIT || pend_v);
        waddr    = (state == INIT) ? ptr : pend_idx;
        wdata    = (state == INIT) ? INIT_CTR : upd_val;
    end

    // single write port: init sweep or stage-B training write
    always_ff @(posedge clk_i) begin
        if (we) mem[waddr] <= wdata;
    end

    // state, sweep pointer, pending stage and registered lookup result
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state      <= INIT;
            ptr        <= '0;
            pend_v     <= 1'b0;
            pend_inc   <= 1'b0;
            pend_idx   <= '0;
            choice_o   <= INIT_CTR;
            choice_v_o <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= (state == INIT) ? ptr + IDX_W'(1) : ptr;
            pend_v     <= train;
            pend_inc   <= global_pred_i == taken_i;
            pend_idx   <= update_idx_i;
            choice_v_o <= lookup_v_i && state == READY;
            if (lookup_v_i && state == READY) choice_o <= look_val;
        end
    end
endmodule

// File: tb/tb_tournament_choice_trainer.sv
// tb_tournament_choice_trainer: directed checks of init sweep, saturating training, bypass timing and reset
module tb_tournament_choice_trainer;
    localparam int IDX_W = 4;

    logic             clk = 0;
    logic             reset_i = 1;
    logic             lookup_v_i = 0;
    logic [IDX_W-1:0] lookup_idx_i = '0;
    logic [1:0]       choice_o;
    logic             choice_v_o;
    logic             update_v_i = 0;
    logic             update_ready_o;
    logic [IDX_W-1:0] update_idx_i = '0;
    logic             global_pred_i = 0;
    logic             local_pred_i = 0;
    logic             taken_i = 0;
    logic             init_done_o;

    int n_tests = 0;
    int n_fail  = 0;

    tournament_choice_trainer #(.IDX_W(IDX_W), .INIT_CTR(2'b01)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .lookup_v_i(lookup_v_i), .lookup_idx_i(lookup_idx_i),
        .choice_o(choice_o), .choice_v_o(choice_v_o),
        .update_v_i(update_v_i), .update_ready_o(update_ready_o),
        .update_idx_i(update_idx_i), .global_pred_i(global_pred_i),
        .local_pred_i(local_pred_i), .taken_i(taken_i),
        .init_done_o(init_done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic upd(input int idx, input logic g, input logic l, input logic t);
        update_v_i = 1; update_idx_i = IDX_W'(idx);
        global_pred_i = g; local_pred_i = l; taken_i = t;
        step();
        update_v_i = 0;
    endtask

    task automatic look(input string tag, input int idx, input int exp);
        lookup_v_i = 1; lookup_idx_i = IDX_W'(idx);
        step();
        lookup_v_i = 0;
        check({tag, "_v"}, int'(choice_v_o), 1);
        check(tag, int'(choice_o), exp);
    endtask

    initial begin
        int n;
        int any_v;
        step(); step();
        check("rst_choice", int'(choice_o), 1);
        check("rst_choice_v", int'(choice_v_o), 0);
        check("rst_ready", int'(update_ready_o), 0);
        check("rst_done", int'(init_done_o), 0);

        // release reset while presenting an increment to idx 0 that must be dropped
        reset_i = 0;
        update_v_i = 1; update_idx_i = '0; global_pred_i = 1; local_pred_i = 0; taken_i = 1;
        n = 0;
        while (n < 40 && !init_done_o) begin
            step(); n++;
        end
        update_v_i = 0;
        check("init_latency", n, 16);
        check("init_ready", int'(update_ready_o), 1);

        look("init_idx0", 0, 1);
        look("init_idx15", 15, 1);
        step();
        check("idle_choice_v", int'(choice_v_o), 0);

        // saturating increment: 1 + 4 must stop at 3
        for (int i = 0; i < 4; i++) upd(3, 1, 0, 1);
        step();
        look("sat_inc", 3, 3);
        upd(3, 1, 0, 0);
        step();
        look("dec_from3", 3, 2);
        step();
        check("hold_choice", int'(choice_o), 2);
        check("hold_choice_v", int'(choice_v_o), 0);

        // saturating decrement then an agreeing packet
        for (int i = 0; i < 3; i++) upd(5, 1, 0, 0);
        step();
        look("sat_dec", 5, 0);
        upd(5, 1, 1, 1);
        step();
        look("agree_nochange", 5, 0);

        // bypass timing: accept at N with lookups at N and N+1
        update_v_i = 1; update_idx_i = 7; global_pred_i = 1; local_pred_i = 0; taken_i = 1;
        lookup_v_i = 1; lookup_idx_i = 7;
        step();
        update_v_i = 0;
        check("byp_n_v", int'(choice_v_o), 1);
        check("byp_n", int'(choice_o), 1);
        step();
        lookup_v_i = 0;
        check("byp_n1", int'(choice_o), 2);

        // reset with an update pending on idx 2 holding 3
        upd(2, 1, 0, 1); upd(2, 1, 0, 1);
        step();
        look("pre_rst_idx2", 2, 3);
        upd(2, 1, 0, 0);
        reset_i = 1;
        step();
        reset_i = 0;
        check("rst_ready_drop", int'(update_ready_o), 0);
        lookup_v_i = 1; lookup_idx_i = 2;
        n = 0; any_v = 0;
        while (n < 40 && !init_done_o) begin
            step(); n++;
            any_v |= int'(choice_v_o);
        end
        lookup_v_i = 0;
        check("reinit_latency", n, 16);
        check("init_lookup_ignored", any_v, 0);
        look("reinit_idx2", 2, 1);
        look("reinit_idx7", 7, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
